// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for both sides of the asynchronous FIFO.
//   FIFO_PTR_WIDTH : default pointer width (wrap bit included)
//   bin2gray       : binary -> reflected Gray code
//   gray2bin       : reflected Gray code -> binary
// Both functions work on a 32-bit container. Callers zero-extend narrower
// pointers and then cast the result back to their own width. Zero upper bits
// stay zero through either conversion, so the low bits are exact for any
// width up to 32.
package fifo_pkg;

  localparam int FIFO_PTR_WIDTH = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a Gray-coded pointer crossing clock
// domains. Only one bit changes per source update, so a metastable capture
// resolves to either the old or the new pointer value.
//   clk : destination-domain clock
//   rst : asynchronous active-high reset, clears both stages
//   d   : asynchronous input bus
//   q   : synchronised output, two destination edges behind d
module sync_2ff #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] q1_d, q1_q;
  logic [width-1:0] q2_d, q2_q;

  always_comb begin
    q1_d = d;
    q2_d = q1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= q1_d;
      q2_q <= q2_d;
    end
  end

  assign q = q2_q;

endmodule

// File: rtl/wr_full_ctrl.sv
// wr_full_ctrl: write-side control stage of the asynchronous FIFO.
// It qualifies write requests, advances the binary write pointer, and
// publishes that pointer in Gray code to the read domain. It also
// resynchronises the read pointer and registers full, almost-full,
// occupancy and sticky overflow status.
//   clk, rst        : write clock; asynchronous active-high reset
//   wr_req          : producer write request
//   rptr_gray_async : Gray read pointer from the read domain
//   wr_en, waddr    : memory write strobe and address (combinational)
//   wptr_gray       : registered Gray write pointer
//   full, almost_full, wr_count, overflow : registered status
module wr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ptr_width = FIFO_PTR_WIDTH,
  parameter int af_margin = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_req,
  input  logic [ptr_width-1:0] rptr_gray_async,
  output logic                 wr_en,
  output logic [ptr_width-2:0] waddr,
  output logic [ptr_width-1:0] wptr_gray,
  output logic                 full,
  output logic                 almost_full,
  output logic [ptr_width-1:0] wr_count,
  output logic                 overflow
);

  localparam int MSB = ptr_width - 1;
  localparam logic [ptr_width-1:0] DEPTH   = {1'b1, {(ptr_width-1){1'b0}}};
  localparam logic [ptr_width-1:0] AF_MARG = ptr_width'(af_margin);

  logic [ptr_width-1:0] wbin_d,  wbin_q;
  logic [ptr_width-1:0] wgray_d, wgray_q;
  logic [ptr_width-1:0] count_d, count_q;
  logic                 full_d,  full_q;
  logic                 af_d,    af_q;
  logic                 ovf_d,   ovf_q;

  logic [ptr_width-1:0] rq2;
  logic [ptr_width-1:0] rbin_s;
  logic [ptr_width-1:0] free_slots;
  logic                 wr_en_c;

  // Stage: read pointer into the write domain (rq1 -> rq2)
  sync_2ff #(
    .width(ptr_width)
  ) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .d   (rptr_gray_async),
    .q   (rq2)
  );

  // Stage: next pointer and status, registered on the write edge
  always_comb begin
    // A write while full is dropped. rst also gates the strobe because
    // full_q is held low during reset.
    wr_en_c    = wr_req & ~full_q & ~rst;
    wbin_d     = wbin_q + {{(ptr_width-1){1'b0}}, wr_en_c};
    wgray_d    = ptr_width'(bin2gray(32'(wbin_d)));
    rbin_s     = ptr_width'(gray2bin(32'(rq2)));
    // Full when the write pointer is exactly one lap ahead of the read
    // pointer. In Gray code a lap flips the top two bits.
    full_d     = (wgray_d == {~rq2[MSB:MSB-1], rq2[MSB-2:0]});
    count_d    = wbin_d - rbin_s;
    free_slots = DEPTH - count_d;
    af_d       = (free_slots <= AF_MARG);
    ovf_d      = ovf_q | (wr_req & full_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      count_q <= count_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_en       = wr_en_c;
  assign waddr       = wbin_q[ptr_width-2:0];
  assign wptr_gray   = wgray_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign wr_count    = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_wr_full_ctrl.sv
// tb_wr_full_ctrl: bench for wr_full_ctrl with ptr_width=4 and af_margin=2.
// A table of vectors gives the inputs for one cycle, the combinational
// strobe/address expected before the edge, and the registered outputs
// expected after it. Expected records go through a scoreboard queue.
// Reset and pointer wrap are written out as hand sequences.
module tb_wr_full_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req;
  logic [3:0] rptr_gray_async;
  logic       wr_en;
  logic [2:0] waddr;
  logic [3:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_count;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       wr_req;
    logic [3:0] rptr;
    logic       wr_en;   // before the edge
    logic [2:0] waddr;   // before the edge
    logic [3:0] gray;    // after the edge
    logic       full;
    logic       af;
    logic [3:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];

  wr_full_ctrl #(.ptr_width(4), .af_margin(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_req          (wr_req),
    .rptr_gray_async (rptr_gray_async),
    .wr_en           (wr_en),
    .waddr           (waddr),
    .wptr_gray       (wptr_gray),
    .full            (full),
    .almost_full     (almost_full),
    .wr_count        (wr_count),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] g4(input logic [3:0] b);
    return b ^ {1'b0, b[3:1]};
  endfunction

  function automatic vec_t mk(input logic rq, input logic [3:0] rp, input logic we,
                              input logic [2:0] wa, input logic [3:0] gr, input logic fu,
                              input logic af, input logic [3:0] cn, input logic ov);
    vec_t v;
    v.wr_req = rq; v.rptr = rp; v.wr_en = we; v.waddr = wa; v.gray = gr;
    v.full = fu; v.af = af; v.cnt = cn; v.ovf = ov;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Call at posedge+1: drive inputs, check the strobe, then check the
  // registered outputs one edge later.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    wr_req = v.wr_req;
    rptr_gray_async = v.rptr;
    #1;
    chk($sformatf("v%0d wr_en", idx), 32'(wr_en), 32'(v.wr_en));
    chk($sformatf("v%0d waddr", idx), 32'(waddr), 32'(v.waddr));
    sb_q.push_back(v);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    chk($sformatf("v%0d wptr_gray", idx), 32'(wptr_gray), 32'(e.gray));
    chk($sformatf("v%0d full", idx), 32'(full), 32'(e.full));
    chk($sformatf("v%0d almost_full", idx), 32'(almost_full), 32'(e.af));
    chk($sformatf("v%0d wr_count", idx), 32'(wr_count), 32'(e.cnt));
    chk($sformatf("v%0d overflow", idx), 32'(overflow), 32'(e.ovf));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " wr_en"}, 32'(wr_en), 0);
    chk({tag, " waddr"}, 32'(waddr), 0);
    chk({tag, " wptr_gray"}, 32'(wptr_gray), 0);
    chk({tag, " full"}, 32'(full), 0);
    chk({tag, " almost_full"}, 32'(almost_full), 0);
    chk({tag, " wr_count"}, 32'(wr_count), 0);
    chk({tag, " overflow"}, 32'(overflow), 0);
  endtask

  initial begin
    logic [3:0] prev_gray;
    logic [3:0] b;

    // Reset state; wr_req high to show that the strobe is gated.
    rst = 1'b1;
    wr_req = 1'b1;
    rptr_gray_async = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill: eight writes with the read pointer at zero.
    //            req rptr  we  wa    gray     full af cnt ovf
    tbl.push_back(mk(1, 4'h0, 1, 3'd0, 4'b0001, 0, 0, 4'd1, 0));
    tbl.push_back(mk(1, 4'h0, 1, 3'd1, 4'b0011, 0, 0, 4'd2, 0));
    tbl.push_back(mk(1, 4'h0, 1, 3'd2, 4'b0010, 0, 0, 4'd3, 0));
    tbl.push_back(mk(1, 4'h0, 1, 3'd3, 4'b0110, 0, 0, 4'd4, 0));
    tbl.push_back(mk(1, 4'h0, 1, 3'd4, 4'b0111, 0, 0, 4'd5, 0));
    tbl.push_back(mk(1, 4'h0, 1, 3'd5, 4'b0101, 0, 1, 4'd6, 0));
    tbl.push_back(mk(1, 4'h0, 1, 3'd6, 4'b0100, 0, 1, 4'd7, 0));
    tbl.push_back(mk(1, 4'h0, 1, 3'd7, 4'b1100, 1, 1, 4'd8, 0));
    // Overflow: three requests while full are dropped; the flag is sticky.
    tbl.push_back(mk(1, 4'h0, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1));
    tbl.push_back(mk(1, 4'h0, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1));
    tbl.push_back(mk(1, 4'h0, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1));
    tbl.push_back(mk(0, 4'h0, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1));
    // Drain visibility: the read advances to 1; it is seen at the third edge.
    tbl.push_back(mk(0, 4'b0001, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 3'd0, 4'b1100, 0, 1, 4'd7, 1));
    // Simultaneous: a write plus a read advance to 2 at wr_count=7.
    tbl.push_back(mk(1, 4'b0011, 1, 3'd0, 4'b1101, 1, 1, 4'd8, 1));
    tbl.push_back(mk(0, 4'b0011, 0, 3'd1, 4'b1101, 1, 1, 4'd8, 1));
    tbl.push_back(mk(0, 4'b0011, 0, 3'd1, 4'b1101, 0, 1, 4'd7, 1));

    foreach (tbl[i]) step(tbl[i], i);
    chk("scoreboard empty", 32'(sb_q.size()), 0);

    // Mid-stream reset: bring wbin to 5, then assert rst between edges.
    rst = 1'b1;
    rptr_gray_async = 4'b0000;
    wr_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_req = 1'b1;
      @(posedge clk); #1;
    end
    chk("pre-reset waddr", 32'(waddr), 5);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async reset");
    #50;
    chk_all_zero("held reset");
    @(posedge clk); #1;
    rst = 1'b0;
    step(mk(1, 4'h0, 1, 3'd0, 4'b0001, 0, 0, 4'd1, 0), 100);

    // Wrap: sixteen writes with the read pointer trailing each write, so
    // full never asserts and wbin wraps 15 -> 0.
    prev_gray = wptr_gray;
    b = 4'd1;
    for (int k = 0; k < 16; k++) begin
      wr_req = 1'b1;
      rptr_gray_async = g4(b);
      #1;
      chk($sformatf("wrap%0d wr_en", k), 32'(wr_en), 1);
      chk($sformatf("wrap%0d waddr", k), 32'(waddr), 32'(b[2:0]));
      @(posedge clk); #1;
      b = b + 4'd1;
      chk($sformatf("wrap%0d wptr_gray", k), 32'(wptr_gray), 32'(g4(b)));
      chk($sformatf("wrap%0d onebit", k), 32'($countones(wptr_gray ^ prev_gray)), 1);
      chk($sformatf("wrap%0d full", k), 32'(full), 0);
      prev_gray = wptr_gray;
    end
    wr_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wr_full_ctrl.md
# wr_full_ctrl

Write-side control stage of the asynchronous FIFO, directly downstream of the write pointer counter. Each cycle it qualifies write requests, advances the binary write pointer, and publishes the Gray-coded pointer to the read domain. It also resynchronises the read pointer into the write clock domain and produces registered full, almost-full, occupancy and overflow status. Its outputs drive the dual-port memory write port and the read-side synchroniser.

## Interface
- ptr_width, 4: pointer width including wrap bit; FIFO depth = 2^(ptr_width-1)
- af_margin, 2: almost_full asserts when free slots <= af_margin
- clk  in  1  write-domain clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_req  in  1  write request from producer
- rptr_gray_async  in  ptr_width  Gray read pointer from read domain (asynchronous)
- wr_en  out  1  memory write strobe = wr_req & ~full (combinational)
- waddr  out  ptr_width-1  memory write address = wbin[ptr_width-2:0]
- wptr_gray  out  ptr_width  registered Gray write pointer to read domain
- full  out  1  registered full flag
- almost_full  out  1  registered
- wr_count  out  ptr_width  registered occupancy as seen from the write side, 0..depth
- overflow  out  1  sticky: wr_req while full; cleared only by rst

## Operation
- Reset (async, rst=1): wbin=0, wptr_gray=0, rq1=rq2=0, full=0, almost_full=0, wr_count=0, overflow=0; waddr=0, wr_en=0 while rst=1.
- Sync: rq1 <= rptr_gray_async; rq2 <= rq1 (2-flop). rbin_s = gray2bin(rq2).
- wbin_next = wbin + wr_en, modulo 2^ptr_width (natural wrap). wgray_next = wbin_next ^ (wbin_next >> 1).
- Full: full <= (wgray_next == {~rq2[MSB:MSB-1], rq2[MSB-2:0]}).
- wr_count <= (wbin_next - rbin_s) mod 2^ptr_width.
- almost_full <= (depth - that count) <= af_margin.
- overflow <= overflow | (wr_req & full).
- Write while full is dropped: no pointer move, no memory strobe.
- Flags are pessimistic: a read becomes visible only after synchronisation, so full may persist for extra cycles but never deasserts early.
- No state machine beyond the pointer/flag registers; the block is a pure registered datapath.

## Timing
- wr_en accepted at edge E → waddr, wptr_gray, full, wr_count updated at E (same edge). The write that fills the FIFO asserts full at its own edge.
- Read-pointer change stable before edge E1: rq1 at E1, rq2 at E2, full/wr_count/almost_full reflect it at E3.
- Simultaneous write and read-pointer change: both combine at E3 via wbin_next and rq2; no lost update.
- wptr_gray changes at most one bit per edge (Gray), including the wrap from 2^ptr_width-1 to 0.
- rst mid-operation: all registers clear asynchronously, independent of clk; the first write after release uses waddr=0.

## Structure
- Shared package fifo_pkg: functions bin2gray and gray2bin (parameterised width), constant for the default ptr_width.
- Sub-module sync_2ff (parameter width): the rq1/rq2 synchroniser, reused on the read side.
- Everything else is inline: pointer register, flag logic, count subtractor.

## Test plan
- Reset: assert rst 50 ns mid-stream with wbin=5 → all outputs 0 immediately, no clk edge needed; after release, first write gives waddr=0, wptr_gray=0001.
- Fill (ptr_width=4, rptr_gray_async=0000): 8 consecutive wr_req.
  - waddr steps 0..7; wptr_gray steps 0001,0011,0010,0110,0111,0101,0100,1100.
  - full=1 at the 8th edge; wr_count=8; almost_full=1 from wr_count=6.
- Overflow: with full=1, hold wr_req 3 cycles → wr_en=0, wptr_gray holds 1100, overflow=1 and stays 1 after wr_req drops.
- Drain visibility: from full, set rptr_gray_async=0001 → full=1 at E1 and E2, full=0 and wr_count=7 at E3.
- Wrap: 16 writes with rptr_gray_async tracking each write's Gray value → wbin 15→0, waddr 7→0, wptr_gray 1000→0000, full never asserts, one-bit change per step checked.
- Simultaneous: at wr_count=7, write and read-pointer advance in the same cycle → full=1 at the write edge, then full=0 and wr_count=7 three edges after the read change.
